// File: rtl/mux4_rr_arbiter.sv
// Four-requester arbiter that owns the select and output of a shared 4:1 mux.
// Round-robin by default; define MUX4_RR_ARBITER_FIXED_PRIO_EN for fixed priority (0 highest).
module mux4_rr_arbiter #(
  parameter int DATA_W   = 1,
  parameter int MAX_HOLD = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [3:0]            req,
  input  logic [4*DATA_W-1:0]   data_in,
  output logic [3:0]            gnt,
  output logic [1:0]            sel,
  output logic                  valid,
  output logic [DATA_W-1:0]     y
);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t      state, state_nxt;
  logic [1:0]  last, last_nxt;
  logic [3:0]  hold_cnt, hold_nxt;
  logic [3:0]  gnt_nxt;
  logic [1:0]  sel_nxt;
  logic        valid_nxt;

  // Ascending search with wrap from 'start'; returns {found, index}.
  function automatic logic [2:0] pick(input logic [3:0] r, input logic [1:0] start);
    logic [1:0] idx;
    logic [2:0] res;
    res = 3'b000;
    for (int i = 0; i < 4; i++) begin
      idx = start + i[1:0];
      if (!res[2] && r[idx]) res = {1'b1, idx};
    end
    return res;
  endfunction

  function automatic logic [1:0] search_start(input logic [1:0] from_last);
`ifdef MUX4_RR_ARBITER_FIXED_PRIO_EN
    search_start = 2'd0 & from_last;
`else
    search_start = from_last + 2'd1;
`endif
  endfunction

  logic [3:0] cand;
  logic [2:0] win;
  logic       release_now;

  always_comb begin
    state_nxt   = state;
    last_nxt    = last;
    hold_nxt    = hold_cnt;
    gnt_nxt     = gnt;
    sel_nxt     = sel;
    valid_nxt   = valid;
    cand        = req;
    win         = 3'b000;
    release_now = 1'b0;

    case (state)
      IDLE: begin
        win = pick(req, search_start(last));
      end
      GRANT: begin
        release_now = !req[sel] || (hold_cnt == 4'(MAX_HOLD - 1));
        // The current owner competes only when nobody else is asking.
        if ((req & ~gnt) != 4'b0000) cand = req & ~gnt;
        if (release_now) win = pick(cand, search_start(sel));
        else             hold_nxt = hold_cnt + 4'd1;
      end
      default: ;
    endcase

    if (win[2]) begin
      state_nxt = GRANT;
      gnt_nxt   = 4'b0001 << win[1:0];
      sel_nxt   = win[1:0];
      last_nxt  = win[1:0];
      hold_nxt  = 4'd0;
      valid_nxt = 1'b1;
    end else if (state == GRANT && release_now) begin
      state_nxt = IDLE;
      gnt_nxt   = 4'b0000;
      valid_nxt = 1'b0;
      last_nxt  = sel;
      hold_nxt  = 4'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      last     <= 2'd3;
      hold_cnt <= 4'd0;
      gnt      <= 4'b0000;
      sel      <= 2'd0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nxt;
      last     <= last_nxt;
      hold_cnt <= hold_nxt;
      gnt      <= gnt_nxt;
      sel      <= sel_nxt;
      valid    <= valid_nxt;
    end
  end

  always_comb begin
    y = '0;
    if (valid) y = data_in[sel*DATA_W +: DATA_W];
  end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios plus random traffic against an ownership/window model.
module tb_mux4_rr_arbiter;

  localparam int DATA_W   = 1;
  localparam int MAX_HOLD = 4;

  logic                clk;
  logic                rst;
  logic [3:0]          req;
  logic [4*DATA_W-1:0] data_in;
  logic [3:0]          gnt;
  logic [1:0]          sel;
  logic                valid;
  logic [DATA_W-1:0]   y;

  int errors;
  int checks;

  // Model: owner index (-1 when idle), cycles already spent in the window, last owner.
  int m_owner;
  int m_held;
  int m_last;
  int m_sel;

  mux4_rr_arbiter #(.DATA_W(DATA_W), .MAX_HOLD(MAX_HOLD)) dut (
    .clk(clk), .rst(rst), .req(req), .data_in(data_in),
    .gnt(gnt), .sel(sel), .valid(valid), .y(y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic int first_from(input logic [3:0] r, input int from);
    for (int n = 0; n < 4; n++)
      if (r[(from + n) % 4]) return (from + n) % 4;
    return -1;
  endfunction

  task automatic model_edge(input logic [3:0] r, input logic rs);
    int w;
    if (rs) begin
      m_owner = -1; m_held = 0; m_last = 3; m_sel = 0;
    end else if (m_owner < 0) begin
      w = first_from(r, (m_last + 1) % 4);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_sel = w; m_last = w;
      end
    end else if (r[m_owner] && m_held < MAX_HOLD) begin
      m_held++;
    end else begin
      // Starting one past the owner leaves the owner for last: it wins only if alone.
      w = first_from(r, (m_owner + 1) % 4);
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_sel = w; m_last = w;
      end else begin
        m_last = m_owner; m_owner = -1; m_held = 0;
      end
    end
  endtask

  task automatic step(input logic [3:0] r, input logic [3:0] d, input logic rs);
    logic [3:0] eg;
    logic       ev;
    logic       ey;
    @(negedge clk);
    req = r; data_in = d; rst = rs;
    @(posedge clk);
    model_edge(r, rs);
    #1;
    ev = (m_owner >= 0);
    eg = ev ? (4'b0001 << m_owner) : 4'b0000;
    ey = ev ? d[m_sel] : 1'b0;
    check("gnt",   32'(gnt),   32'(eg));
    check("sel",   32'(sel),   32'(m_sel));
    check("valid", 32'(valid), 32'(ev));
    check("y",     32'(y),     32'(ey));
  endtask

  initial begin
    logic [3:0] r;
    errors = 0; checks = 0;
    m_owner = -1; m_held = 0; m_last = 3; m_sel = 0;
    req = 4'b0000; data_in = 4'b0000; rst = 1'b1;

    // Reset then idle with changing data.
    step(4'b0000, 4'b1111, 1'b1);
    for (int i = 0; i < 5; i++) step(4'b0000, 4'($urandom_range(0, 15)), 1'b0);

    // Sole requester 2 keeps ownership across window boundaries.
    for (int i = 0; i < 12; i++) step(4'b0100, (i % 2 == 0) ? 4'b0100 : 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // All requesting: full rotation with 4-cycle windows.
    for (int i = 0; i < 20; i++) step(4'b1111, 4'($urandom_range(0, 15)), 1'b0);
    step(4'b0000, 4'b0000, 1'b0);
    step(4'b0000, 4'b0000, 1'b1);

    // Requester 0 drops early, requester 1 takes over.
    for (int i = 0; i < 3; i++) step(4'b0011, 4'b0010, 1'b0);
    for (int i = 0; i < 6; i++) step(4'b0010, 4'b0010, 1'b0);
    step(4'b0000, 4'b0000, 1'b0);

    // Reset mid-grant, then search restarts at requester 0.
    step(4'b0000, 4'b0000, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1000, 4'b1000, 1'b0);
    step(4'b1000, 4'b1000, 1'b1);
    for (int i = 0; i < 3; i++) step(4'b1010, 4'b1010, 1'b0);
    step(4'b0000, 4'b1010, 1'b0);

    // Each requester alone with data 1010, then idle with data present.
    for (int k = 0; k < 4; k++) begin
      step(4'b0001 << k, 4'b1010, 1'b0);
      step(4'b0001 << k, 4'b1010, 1'b0);
      step(4'b0000, 4'b1010, 1'b0);
    end
    step(4'b0000, 4'b1111, 1'b0);

    // Random traffic with held request patterns and occasional reset.
    r = 4'b0000;
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) r = 4'($urandom_range(0, 15));
      step(r, 4'($urandom_range(0, 15)), ($urandom_range(0, 63) == 0));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
